rr_stream_arbiter: RTL and testbench
====================================

Name: rr_stream_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready stream, typically a D_Fifo-style buffer input, among numInputs requesting PEs/ports.
- Grants one requester at a time and holds the grant for a burst of up to burstLen beats.
- Drives a single registered output stage tagged with the source ID.
- Sits between the CGRA interconnect sources and a shared FIFO/memory port.

Parameters:
- dataWidth, 32, width of each data beat
- numInputs, 4, number of requesters; must satisfy 2 <= numInputs <= 2^idWidth
- idWidth, 2, width of the source-ID tag
- burstLen, 4, maximum consecutive beats per grant; must be >= 1

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- din  input  numInputs*dataWidth  flattened inputs; requester i occupies bits [i*dataWidth +: dataWidth]
- dinValid  input  numInputs  per-requester valid
- dinReady  output  numInputs  per-requester ready; at most one bit high
- dout  output  dataWidth  registered output data
- doutValid  output  1  registered output valid
- doutReady  input  1  downstream ready
- doutId  output  idWidth  index of the requester that produced dout
- busy  output  1  high while in GRANT

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, ptr=0, grant=0, count=0, dout=0, doutId=0, doutValid=0. A beat held in dout at reset is discarded.
- Output stage: canLoad = ~doutValid | doutReady.
- State IDLE:
  - dinReady = all zeros.
  - If any dinValid bit is high, select the first index i with dinValid[i]==1, searching ptr, ptr+1, ... with wrap modulo numInputs.
  - Then grant<=i, count<=0, state<=GRANT.
  - Arbitration takes one cycle, with no data transfer in that cycle.
- State GRANT:
  - dinReady[grant] = canLoad; all other dinReady bits = 0 (combinational).
  - Transfer occurs when dinValid[grant] & dinReady[grant]. On transfer: dout<=din slice[grant], doutId<=grant, doutValid<=1, count<=count+1.
  - Release conditions:
    - a transfer with count==burstLen-1;
    - dinValid[grant]==0 in this cycle, with no transfer.
  - On release: state<=IDLE, ptr<=(grant+1) mod numInputs, count<=0. Wrap from numInputs-1 to 0 is explicit; no power-of-two assumption.
  - Stall (dinValid[grant]==1, canLoad==0): hold grant and count; no release.
- doutValid update:
  - Set on a transfer.
  - Otherwise cleared when doutReady==1.
  - Otherwise held.
  - A transfer and a downstream pop in the same cycle leave doutValid=1 with the new data (full throughput inside a burst).
- Latency:
  - First beat of a burst: request seen in IDLE at cycle N → dinReady at cycle N+1 → dout/doutValid at cycle N+2.
  - Subsequent beats: 1 cycle per beat.
  - Each grant change costs one idle arbitration cycle.
- count width: clog2(burstLen)+1 bits; never exceeds burstLen-1 at a clock edge.
- busy = (state==GRANT).
- Fairness: after any release, the previously granted requester has lowest priority. No requester waits more than (numInputs-1) bursts.
- Protocol: dinValid deassertion without a transfer is legal and ends the grant. Data on non-granted inputs is ignored.

Test Plan:
- Reset then single requester 2 valid with din2=0xA0..0xA5 (6 beats), doutReady=1 → beats 0xA0–0xA3 appear with doutId=2. One IDLE bubble follows, then 0xA4–0xA5. dinReady only ever 0b0100.
- All four requesters valid continuously, burstLen=4, doutReady=1 → grant order 0,1,2,3,0. 4 beats each. doutId sequence matches. One bubble per switch.
- Requester 1 drops valid after 2 beats while requester 3 is valid → release after 2 beats, ptr=2, next grant=3. dout shows 2 beats with doutId=1, then doutId=3.
- Backpressure: doutReady=0 for 5 cycles mid-burst → dout/doutId held stable, doutValid=1, dinReady[grant]=0, count unchanged. Burst resumes with no loss or duplication when doutReady returns to 1.
- Asynchronous reset asserted mid-burst, between clock edges → doutValid=0, dinReady=0, busy=0 immediately. After release, the first grant goes to the lowest valid index from ptr=0.
- burstLen=1, requesters 0 and 3 always valid → alternating grants 0,3,0,3 with one beat each. Wrap 3→0 is verified.

Source files
------------

// File: rtl/rr_stream_arbiter_if.sv
// Stream bundle for rr_stream_arbiter: N flattened requester lanes in, one tagged beat out.
interface rr_stream_arbiter_if #(
  parameter int dataWidth = 32,
  parameter int numInputs = 4,
  parameter int idWidth   = 2
);
  logic [numInputs*dataWidth-1:0] din;
  logic [numInputs-1:0]           dinValid;
  logic [numInputs-1:0]           dinReady;
  logic [dataWidth-1:0]           dout;
  logic                           doutValid;
  logic                           doutReady;
  logic [idWidth-1:0]             doutId;

  modport master (
    output din, dinValid, doutReady,
    input  dinReady, dout, doutValid, doutId
  );

  modport slave (
    input  din, dinValid, doutReady,
    output dinReady, dout, doutValid, doutId
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready stream among numInputs requesters,
// granting bursts of up to burstLen beats and tagging each beat with its source index.
//
//   state | meaning
//   IDLE  | no owner; pick next valid requester starting at ptr (one cycle, no transfer)
//   GRANT | grant owns the stream until burstLen beats or it drops valid
module rr_stream_arbiter #(
  parameter int dataWidth = 32,
  parameter int numInputs = 4,
  parameter int idWidth   = 2,
  parameter int burstLen  = 4
) (
  input  logic               clock,
  input  logic               reset,
  rr_stream_arbiter_if.slave bus,
  output logic               busy
);
  localparam int CntW = $clog2(burstLen) + 1;
  localparam logic [CntW-1:0]    LastBeat = CntW'(burstLen - 1);
  localparam logic [idWidth-1:0] LastIdx  = idWidth'(numInputs - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_nxt;
  logic [idWidth-1:0]   ptr, ptr_nxt;
  logic [idWidth-1:0]   grant, grant_nxt;
  logic [idWidth-1:0]   pick;
  logic                 found;
  logic [CntW-1:0]      count, count_nxt;
  logic [numInputs-1:0] ready;
  logic                 can_load;
  logic                 xfer;
  logic [dataWidth-1:0] dout_q;
  logic [idWidth-1:0]   id_q;
  logic                 valid_q;

  assign can_load = ~valid_q | bus.doutReady;

  // Walk from the highest offset down so the nearest valid index after ptr wins.
  always_comb begin : rr_pick
    int idx;
    pick  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = numInputs - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= numInputs) idx = idx - numInputs;
      if (bus.dinValid[idx]) begin
        pick  = idWidth'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    count_nxt = count;
    ready     = '0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          count_nxt = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        ready[grant] = can_load;
        xfer         = bus.dinValid[grant] & can_load;
        if (xfer) count_nxt = count + CntW'(1);
        // A dropped valid can never coincide with a transfer, so it always ends the grant.
        if ((xfer && count == LastBeat) || !bus.dinValid[grant]) begin
          state_nxt = IDLE;
          ptr_nxt   = (grant == LastIdx) ? '0 : grant + idWidth'(1);
          count_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      count   <= '0;
      dout_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
      count <= count_nxt;
      if (xfer) begin
        dout_q  <= bus.din[grant*dataWidth +: dataWidth];
        id_q    <= grant;
        valid_q <= 1'b1;
      end else if (bus.doutReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.dinReady  = ready;
  assign bus.dout      = dout_q;
  assign bus.doutValid = valid_q;
  assign bus.doutId    = id_q;
  assign busy          = (state == GRANT);
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: burstLen=4 and burstLen=1 instances, each checked every cycle
// against an owner/ptr/beat-count model, plus literal beat sequences for the directed scenarios.
module tb_rr_stream_arbiter;
  localparam int DW = 32;
  localparam int NI = 4;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy4, busy1;

  rr_stream_arbiter_if #(.dataWidth(DW), .numInputs(NI), .idWidth(IW)) bus4 ();
  rr_stream_arbiter_if #(.dataWidth(DW), .numInputs(NI), .idWidth(IW)) bus1 ();

  rr_stream_arbiter #(.dataWidth(DW), .numInputs(NI), .idWidth(IW), .burstLen(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4), .busy(busy4));
  rr_stream_arbiter #(.dataWidth(DW), .numInputs(NI), .idWidth(IW), .burstLen(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .busy(busy1));

  initial forever #5 clock = ~clock;

  // owner < 0 means nobody holds the stream
  typedef struct {
    int            owner;
    int            cnt;
    int            ptr;
    logic [DW-1:0] dout;
    int            id;
    bit            vld;
  } mdl_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            cyc;
  } beat_t;

  mdl_t          mdl [2];
  beat_t         log4[$];
  beat_t         log1[$];
  int            rem  [2][NI];
  logic [DW-1:0] dat  [2][NI];
  bit            en   [2][NI];
  bit            fire [2][NI];
  int            cyc_n = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.owner = -1; m.cnt = 0; m.ptr = 0; m.dout = '0; m.id = 0; m.vld = 1'b0;
    return m;
  endfunction

  function automatic logic [NI-1:0] mdl_ready(input mdl_t m, input logic rdy);
    logic [NI-1:0] r = '0;
    if (m.owner >= 0 && (!m.vld || rdy)) r[m.owner] = 1'b1;
    return r;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int bl, input logic [NI-1:0] v,
                                    input logic [NI*DW-1:0] d, input logic rdy);
    mdl_t n = m;
    bit   rel = 1'b0;
    if (m.owner < 0) begin
      if (rdy) n.vld = 1'b0;
      for (int k = 0; k < NI; k++)
        if (n.owner < 0 && v[(m.ptr + k) % NI]) n.owner = (m.ptr + k) % NI;
      n.cnt = 0;
    end else if (v[m.owner] && (!m.vld || rdy)) begin
      n.dout = d[m.owner*DW +: DW];
      n.id   = m.owner;
      n.vld  = 1'b1;
      n.cnt  = m.cnt + 1;
      rel    = (n.cnt == bl);
    end else begin
      if (rdy) n.vld = 1'b0;
      rel = !v[m.owner];
    end
    if (rel) begin
      n.ptr   = (m.owner + 1) % NI;
      n.owner = -1;
      n.cnt   = 0;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, got, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [NI-1:0] rdy_o, input logic bsy,
                           input logic vld, input logic [DW-1:0] dq, input logic [IW-1:0] idq,
                           input logic rdy_in);
    mdl_t m = mdl[d];
    chk($sformatf("dut%0d busy", d), 64'(bsy), 64'(m.owner >= 0));
    chk($sformatf("dut%0d dinReady", d), 64'(rdy_o), 64'(mdl_ready(m, rdy_in)));
    chk($sformatf("dut%0d doutValid", d), 64'(vld), 64'(m.vld));
    chk($sformatf("dut%0d dout", d), 64'(dq), 64'(m.dout));
    chk($sformatf("dut%0d doutId", d), 64'(idq), 64'(m.id));
  endtask

  always @(negedge clock) begin
    beat_t b;
    cyc_n++;
    if (!reset) begin
      mdl[0] = mdl_reset();
      mdl[1] = mdl_reset();
    end
    check_dut(0, bus4.dinReady, busy4, bus4.doutValid, bus4.dout, bus4.doutId, bus4.doutReady);
    check_dut(1, bus1.dinReady, busy1, bus1.doutValid, bus1.dout, bus1.doutId, bus1.doutReady);
    if (reset) begin
      if (bus4.doutValid && bus4.doutReady) begin
        b.id = int'(bus4.doutId); b.data = bus4.dout; b.cyc = cyc_n;
        log4.push_back(b);
      end
      if (bus1.doutValid && bus1.doutReady) begin
        b.id = int'(bus1.doutId); b.data = bus1.dout; b.cyc = cyc_n;
        log1.push_back(b);
      end
      for (int i = 0; i < NI; i++) begin
        fire[0][i] = bus4.dinValid[i] & bus4.dinReady[i];
        fire[1][i] = bus1.dinValid[i] & bus1.dinReady[i];
      end
      mdl[0] = mdl_next(mdl[0], 4, bus4.dinValid, bus4.din, bus4.doutReady);
      mdl[1] = mdl_next(mdl[1], 1, bus1.dinValid, bus1.din, bus1.doutReady);
    end else begin
      for (int i = 0; i < NI; i++) begin
        fire[0][i] = 1'b0;
        fire[1][i] = 1'b0;
      end
    end
  end

  // Sources: each lane offers rem[] beats of incrementing data, advancing on accepted beats.
  always begin : drv
    logic [NI-1:0]    v0, v1;
    logic [NI*DW-1:0] d0, d1;
    @(posedge clock);
    #2;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NI; i++)
        if (fire[d][i] && rem[d][i] > 0) begin
          rem[d][i] = rem[d][i] - 1;
          dat[d][i] = dat[d][i] + 1;
        end
    for (int i = 0; i < NI; i++) begin
      v0[i] = en[0][i] && rem[0][i] > 0;
      v1[i] = en[1][i] && rem[1][i] > 0;
      d0[i*DW +: DW] = dat[0][i];
      d1[i*DW +: DW] = dat[1][i];
    end
    bus4.dinValid = v0;
    bus4.din      = d0;
    bus1.dinValid = v1;
    bus1.din      = d1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_beats(input int d, input int n, input int budget, input string name);
    int k = 0;
    while (((d == 0) ? log4.size() : log1.size()) < n && k < budget) begin
      tick(1);
      k++;
    end
    chk({name, " timeout"}, 64'(((d == 0) ? log4.size() : log1.size()) >= n), 64'd1);
  endtask

  initial begin
    int            exp_id [8];
    logic [DW-1:0] exp_d  [8];
    int            id, seq;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NI; i++) begin
        rem[d][i] = 0; dat[d][i] = '0; en[d][i] = 1'b1; fire[d][i] = 1'b0;
      end
    mdl[0] = mdl_reset();
    mdl[1] = mdl_reset();
    bus4.din = '0; bus4.dinValid = '0; bus4.doutReady = 1'b1;
    bus1.din = '0; bus1.dinValid = '0; bus1.doutReady = 1'b1;
    reset = 1'b0;
    tick(3);
    chk("reset busy", 64'(busy4), 64'd0);
    chk("reset doutValid", 64'(bus4.doutValid), 64'd0);
    reset = 1'b1;

    // single requester 2, six beats: 4-beat burst, one bubble, then 2 more
    rem[0][2] = 6; dat[0][2] = 32'hA0;
    wait_beats(0, 6, 60, "t1 beats");
    for (int j = 0; j < 6; j++) begin
      chk("t1 id", 64'(log4[j].id), 64'd2);
      chk("t1 data", 64'(log4[j].data), 64'(32'hA0 + j));
    end
    chk("t1 in-burst spacing", 64'(log4[1].cyc - log4[0].cyc), 64'd1);
    chk("t1 regrant spacing", 64'(log4[4].cyc - log4[3].cyc), 64'd2);
    tick(6);
    log4.delete();

    // async reset mid-burst, then requesters 1 (2 beats) and 3 (6 beats) from ptr=0
    rem[0][3] = 10; dat[0][3] = 32'hC0;
    wait_beats(0, 2, 40, "t5 pre-reset");
    chk("t5 busy before reset", 64'(busy4), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5 async doutValid", 64'(bus4.doutValid), 64'd0);
    chk("t5 async busy", 64'(busy4), 64'd0);
    chk("t5 async dinReady", 64'(bus4.dinReady), 64'd0);
    for (int i = 0; i < NI; i++) rem[0][i] = 0;
    rem[0][1] = 2; dat[0][1] = 32'h10;
    rem[0][3] = 6; dat[0][3] = 32'h30;
    log4.delete();
    tick(3);
    reset = 1'b1;
    wait_beats(0, 8, 80, "t3 beats");
    exp_id = '{1, 1, 3, 3, 3, 3, 3, 3};
    exp_d  = '{32'h10, 32'h11, 32'h30, 32'h31, 32'h32, 32'h33, 32'h34, 32'h35};
    for (int j = 0; j < 8; j++) begin
      chk("t3 id", 64'(log4[j].id), 64'(exp_id[j]));
      chk("t3 data", 64'(log4[j].data), 64'(exp_d[j]));
    end
    tick(6);
    log4.delete();

    // all four requesters, with a 5-cycle downstream stall inside requester 1's burst
    for (int i = 0; i < NI; i++) begin
      rem[0][i] = 20;
      dat[0][i] = 32'hB000_0000 | (32'(i) << 16);
    end
    wait_beats(0, 6, 60, "t2 pre-stall");
    bus4.doutReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4 stall doutValid", 64'(bus4.doutValid), 64'd1);
      chk("t4 stall dinReady", 64'(bus4.dinReady), 64'd0);
      chk("t4 stall busy", 64'(busy4), 64'd1);
      tick(1);
    end
    bus4.doutReady = 1'b1;
    wait_beats(0, 20, 300, "t2 beats");
    for (int j = 0; j < 20; j++) begin
      id  = (j / 4) % 4;
      seq = (j / 16) * 4 + j % 4;
      chk("t2 id", 64'(log4[j].id), 64'(id));
      chk("t2 data", 64'(log4[j].data), 64'((32'hB000_0000 | (32'(id) << 16)) + 32'(seq)));
    end

    // burstLen=1 instance: requesters 0 and 3 alternate, wrapping 3 -> 0
    reset = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NI; i++) rem[d][i] = 0;
    tick(2);
    rem[1][0] = 50; dat[1][0] = 32'h0;
    rem[1][3] = 50; dat[1][3] = 32'h300;
    log1.delete();
    reset = 1'b1;
    wait_beats(1, 8, 80, "t6 beats");
    for (int j = 0; j < 8; j++) begin
      chk("t6 id", 64'(log1[j].id), (j % 2 == 1) ? 64'd3 : 64'd0);
      chk("t6 data", 64'(log1[j].data), 64'(((j % 2 == 1) ? 32'h300 : 32'h0) + 32'(j / 2)));
      if (j < 7) chk("t6 spacing", 64'(log1[j+1].cyc - log1[j].cyc), 64'd2);
    end

    // random traffic on both instances, with one mid-run async reset
    for (int k = 0; k < 3000; k++) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NI; i++) begin
          en[d][i] = ($urandom_range(0, 4) != 0);
          if (rem[d][i] == 0 && $urandom_range(0, 3) == 0) rem[d][i] = $urandom_range(1, 9);
        end
      bus4.doutReady = ($urandom_range(0, 3) != 0);
      bus1.doutReady = ($urandom_range(0, 3) != 0);
      if (k == 1500) begin
        #2;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
      end else begin
        tick(1);
      end
    end
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
